membuf_write_arbiter: RTL and testbench
=======================================

MEMBUF_WRITE_ARBITER -- requirements
Module: membuf_write_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DW, default 256, requester payload width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  input  1  grants allowed when 1.
REQ-006 SHALL have port capacity  input  64  ring size in entries, quasi-static.
REQ-007 SHALL have port req_valid  input  N_REQ  per-requester payload valid.
REQ-008 SHALL have port req_data  input  N_REQ*DW  requester i payload at bits [i*DW +: DW].
REQ-009 SHALL have port req_ready  output  N_REQ  one-hot accept strobe.
REQ-010 SHALL have port tx_full  input  1  write server cannot take a message.
REQ-011 SHALL have port tx_valid  output  1  one-cycle message strobe to the write server.
REQ-012 SHALL have port tx_addr  output  64  ring offset, sent as message arg1.
REQ-013 SHALL have port tx_data  output  512  message payload.
REQ-014 SHALL have port rx_valid  input  1  write server response present (not empty).
REQ-015 SHALL have port rx_tail  input  64  host tail pointer, from response arg1.
REQ-016 SHALL have port rx_pop  output  1  response consumed.
REQ-017 SHALL have port head  output  64  next ring offset to write.
REQ-018 SHALL have port tail  output  64  last valid host tail.
REQ-019 SHALL have port tail_err  output  1  sticky: out-of-range tail received.

Function
REQ-020 SHALL implement FSM states IDLE and SEND; reset state IDLE.
REQ-021 SHALL define ring_full = (next_head == tail), next_head = (head+1 >= capacity) ? 0 : head+1; all 64-bit unsigned.
REQ-022 SHALL, in IDLE with enable=1, capacity>=2, !ring_full and any req_valid, assert req_ready combinationally for the round-robin winner only, and go to SEND at the next edge.
REQ-023 SHALL pick the round-robin winner as the first valid index searching upward (with wrap) from last_grant+1; last_grant resets to N_REQ-1, so index 0 has first priority.
REQ-024 SHALL, on acceptance, latch winner payload and index, update last_grant, and leave req_ready all-zero in every other case.
REQ-025 SHALL, in SEND with tx_full=0, at the next edge: tx_valid=1, tx_addr=head, head=next_head, serial+=1, state=IDLE.
REQ-026 SHALL hold state SEND with tx_valid=0 while tx_full=1; latched payload is retained and nothing is dropped.
REQ-027 SHALL set tx_data = {64'hFEEDFACE, serial, head, winner index zero-extended to 64, payload zero-extended to 256}, with the MSB first.
REQ-028 SHALL keep the internal serial at 1 after reset and increment it with wrap per message; tx_valid SHALL be high for exactly one cycle per message.
REQ-029 SHALL drive rx_pop = rx_valid combinationally.
REQ-030 SHALL, on rx_valid with rx_tail < capacity, load tail <= rx_tail; otherwise keep tail and set tail_err=1 until reset.
REQ-031 SHALL evaluate ring_full from registered tail; a tail update and a grant in the same cycle use the old tail.
REQ-032 SHALL finish a SEND already in progress when enable falls; new grants SHALL stop.
REQ-033 SHALL treat capacity<2 as no space: no grants.
REQ-034 SHALL give peak throughput of one message per two cycles.

Reset
REQ-035 SHALL asynchronously clear on rst_n=0: state IDLE, tx_valid 0, tx_addr 0, tx_data 0, head 0, tail 0, tail_err 0, serial 1, last_grant N_REQ-1; req_ready and rx_pop follow their combinational rules.
REQ-036 SHALL discard any latched message when reset asserts in SEND; no tx_valid until a new grant after reset.

Verification
REQ-037 Single requester: capacity=8, req_valid=4'b0001, data=A -> req_ready[0] for 1 cycle, tx_valid 2 cycles later, tx_addr=0, tx_data[447:384]=1, [255:0]=A, head=1.
REQ-038 Round robin: all four valid continuously -> grant order 0,1,2,3,0; tx_addr 0..4.
REQ-039 Backpressure: tx_full=1 for 5 cycles in SEND -> no tx_valid and no req_ready; one tx_valid 1 cycle after tx_full drops; payload unchanged.
REQ-040 Ring full/wrap: capacity=4, tail=0 -> 3 messages (addr 0,1,2) then stall; rx_valid with rx_tail=2 -> 2 more messages at addr 3,0.
REQ-041 Bad tail: capacity=4, rx_tail=9 -> tail unchanged, tail_err=1, rx_pop=1 for that cycle.
REQ-042 Reset mid-SEND: rst_n low during tx_full=1 -> all outputs at reset values; after release first message has serial=1, tx_addr=0.

Source files
------------

// File: rtl/membuf_write_arbiter.sv
// membuf_write_arbiter: round-robin requester arbiter feeding a ring buffer
// write server, with head/tail tracking from host tail responses.
module membuf_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [63:0]         capacity,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                tx_full,
  output logic                tx_valid,
  output logic [63:0]         tx_addr,
  output logic [511:0]        tx_data,
  input  logic                rx_valid,
  input  logic [63:0]         rx_tail,
  output logic                rx_pop,
  output logic [63:0]         head,
  output logic [63:0]         tail,
  output logic                tail_err
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  logic [0:0]    state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] idx_q;
  logic [DW-1:0] pay_q;
  logic [255:0]  pay_ext;
  logic [63:0]   serial;
  logic [63:0]   head_inc;
  logic [63:0]   next_head;
  logic          ring_full;
  logic          cap_ok;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic          grant;

  // payload field of the message is fixed at 256 bits
  if (DW >= 256) begin : g_trunc
    assign pay_ext = pay_q[255:0];
  end else begin : g_ext
    assign pay_ext = {{(256-DW){1'b0}}, pay_q};
  end

  // ring occupancy: full when the next write would land on the host tail
  always_comb begin
    head_inc  = head + 64'd1;
    next_head = (head_inc >= capacity) ? 64'd0 : head_inc;
    ring_full = (next_head == tail);
    cap_ok    = (capacity >= 64'd2);
  end

  // round-robin search upward from the slot after the last grant
  always_comb begin : win_search
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(last_grant) + k) % N_REQ;
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

  // one-hot accept strobe for the winner only
  always_comb begin
    grant = (state == IDLE) && enable && cap_ok
            && !ring_full && win_found;
    req_ready = '0;
    if (grant) req_ready[win_idx] = 1'b1;
    rx_pop = rx_valid;
  end

  // grant/send FSM with message formatting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= LAST_RST;
      idx_q      <= '0;
      pay_q      <= '0;
      serial     <= 64'd1;
      head       <= 64'd0;
      tx_valid   <= 1'b0;
      tx_addr    <= 64'd0;
      tx_data    <= '0;
    end else begin
      tx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            pay_q      <= req_data[win_idx*DW +: DW];
            idx_q      <= win_idx;
            last_grant <= win_idx;
            state      <= SEND;
          end
        end
        SEND: begin
          if (!tx_full) begin
            tx_valid <= 1'b1;
            tx_addr  <= head;
            tx_data  <= {64'hFEEDFACE, serial, head,
                         64'(idx_q), pay_ext};
            head     <= next_head;
            serial   <= serial + 64'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // host tail tracking; out-of-range tails are flagged and ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail     <= 64'd0;
      tail_err <= 1'b0;
    end else if (rx_valid) begin
      if (rx_tail < capacity) tail <= rx_tail;
      else tail_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_membuf_write_arbiter.sv
// tb_membuf_write_arbiter: directed checks of arbitration, backpressure,
// ring wrap, tail validation and reset behaviour.
module tb_membuf_write_arbiter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [63:0]   capacity;
  logic [3:0]    req_valid;
  logic [1023:0] req_data;
  logic [3:0]    req_ready;
  logic          tx_full;
  logic          tx_valid;
  logic [63:0]   tx_addr;
  logic [511:0]  tx_data;
  logic          rx_valid;
  logic [63:0]   rx_tail;
  logic          rx_pop;
  logic [63:0]   head;
  logic [63:0]   tail;
  logic          tail_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [255:0] pay [4];

  membuf_write_arbiter #(.N_REQ(4), .DW(256)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .capacity(capacity), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready),
    .tx_full(tx_full), .tx_valid(tx_valid),
    .tx_addr(tx_addr), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_tail(rx_tail),
    .rx_pop(rx_pop), .head(head), .tail(tail),
    .tail_err(tail_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] msg(input logic [63:0] ser,
                                       input logic [63:0] adr,
                                       input logic [63:0] idx,
                                       input logic [255:0] p);
    return {64'hFEEDFACE, ser, adr, idx, p};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_txv"}, 512'(tx_valid), 512'd0);
    chk({tag, "_addr"}, 512'(tx_addr), 512'd0);
    chk({tag, "_data"}, tx_data, 512'd0);
    chk({tag, "_head"}, 512'(head), 512'd0);
    chk({tag, "_tail"}, 512'(tail), 512'd0);
    chk({tag, "_terr"}, 512'(tail_err), 512'd0);
  endtask

  initial begin
    pay[0] = {8{32'hA0A0_0001}};
    pay[1] = {8{32'hB1B1_0002}};
    pay[2] = {8{32'hC2C2_0003}};
    pay[3] = {8{32'hD3D3_0004}};
    rst_n = 1'b0;
    enable = 1'b0;
    capacity = 64'd8;
    req_valid = 4'b0000;
    req_data = '0;
    tx_full = 1'b0;
    rx_valid = 1'b0;
    rx_tail = 64'd0;
    #1;
    chk_reset_outs("rst");
    chk("rst_rdy", 512'(req_ready), 512'd0);
    chk("rst_pop", 512'(rx_pop), 512'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // single requester
    enable = 1'b1;
    req_data[255:0] = pay[0];
    req_valid = 4'b0001;
    #1;
    chk("single_rdy", 512'(req_ready), 512'd1);
    tick();
    req_valid = 4'b0000;
    chk("single_rdy_send", 512'(req_ready), 512'd0);
    chk("single_txv_early", 512'(tx_valid), 512'd0);
    tick();
    chk("single_txv", 512'(tx_valid), 512'd1);
    chk("single_addr", 512'(tx_addr), 512'd0);
    chk("single_ser", 512'(tx_data[447:384]), 512'd1);
    chk("single_pay", 512'(tx_data[255:0]), 512'(pay[0]));
    chk("single_msg", tx_data, msg(64'd1, 64'd0, 64'd0, pay[0]));
    chk("single_head", 512'(head), 512'd1);
    tick();
    chk("single_txv_pulse", 512'(tx_valid), 512'd0);

    // round robin with all requesters valid
    do_reset();
    for (int k = 0; k < 4; k++) req_data[k*256 +: 256] = pay[k];
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr%0d_rdy", k), 512'(req_ready),
          512'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("rr%0d_rdy_send", k), 512'(req_ready), 512'd0);
      tick();
      if (k == 4) req_valid = 4'b0000;
      chk($sformatf("rr%0d_txv", k), 512'(tx_valid), 512'd1);
      chk($sformatf("rr%0d_addr", k), 512'(tx_addr), 512'(k));
      chk($sformatf("rr%0d_msg", k), tx_data,
          msg(64'(k + 1), 64'(k), 64'(k % 4), pay[k % 4]));
    end

    // backpressure while in SEND
    do_reset();
    req_valid = 4'b0010;
    #1;
    chk("bp_rdy", 512'(req_ready), 512'd2);
    tick();
    tx_full = 1'b1;
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp%0d_txv", k), 512'(tx_valid), 512'd0);
      chk($sformatf("bp%0d_rdy", k), 512'(req_ready), 512'd0);
    end
    tx_full = 1'b0;
    req_valid = 4'b0000;
    tick();
    chk("bp_txv", 512'(tx_valid), 512'd1);
    chk("bp_msg", tx_data, msg(64'd1, 64'd0, 64'd1, pay[1]));
    tick();
    chk("bp_txv_pulse", 512'(tx_valid), 512'd0);

    // enable falls mid-SEND: message completes, no new grant
    req_valid = 4'b0100;
    tick();
    enable = 1'b0;
    tick();
    chk("en_txv", 512'(tx_valid), 512'd1);
    chk("en_msg", tx_data, msg(64'd2, 64'd1, 64'd2, pay[2]));
    chk("en_rdy", 512'(req_ready), 512'd0);
    enable = 1'b1;
    capacity = 64'd1;
    #1;
    chk("cap1_rdy", 512'(req_ready), 512'd0);
    req_valid = 4'b0000;

    // ring full and wrap with capacity 4
    capacity = 64'd8;
    do_reset();
    capacity = 64'd4;
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      tick();
      chk($sformatf("ring%0d_addr", k), 512'(tx_addr), 512'(k));
      chk($sformatf("ring%0d_txv", k), 512'(tx_valid), 512'd1);
    end
    chk("ring_full_rdy", 512'(req_ready), 512'd0);
    tick();
    tick();
    chk("ring_stall_txv", 512'(tx_valid), 512'd0);
    chk("ring_stall_head", 512'(head), 512'd3);
    rx_valid = 1'b1;
    rx_tail = 64'd2;
    #1;
    chk("ring_pop", 512'(rx_pop), 512'd1);
    chk("ring_old_tail_rdy", 512'(req_ready), 512'd0);
    tick();
    rx_valid = 1'b0;
    chk("ring_tail", 512'(tail), 512'd2);
    chk("ring_resume_rdy", 512'(req_ready), 512'd1);
    tick();
    tick();
    chk("ring3_msg", tx_data, msg(64'd4, 64'd3, 64'd0, pay[0]));
    chk("ring3_head", 512'(head), 512'd0);
    tick();
    tick();
    chk("ring4_addr", 512'(tx_addr), 512'd0);
    chk("ring4_txv", 512'(tx_valid), 512'd1);
    chk("ring4_ser", 512'(tx_data[447:384]), 512'd5);
    chk("ring_full2_rdy", 512'(req_ready), 512'd0);
    req_valid = 4'b0000;

    // out-of-range tail
    rx_valid = 1'b1;
    rx_tail = 64'd9;
    #1;
    chk("bad_pop", 512'(rx_pop), 512'd1);
    tick();
    rx_valid = 1'b0;
    #1;
    chk("bad_tail", 512'(tail), 512'd2);
    chk("bad_err", 512'(tail_err), 512'd1);
    chk("bad_pop_off", 512'(rx_pop), 512'd0);
    rx_valid = 1'b1;
    rx_tail = 64'd3;
    tick();
    rx_valid = 1'b0;
    chk("good_tail", 512'(tail), 512'd3);
    chk("err_sticky", 512'(tail_err), 512'd1);

    // reset asserted mid-SEND under backpressure
    req_data[255:0] = pay[3];
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    tx_full = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid");
    chk("mid_rdy", 512'(req_ready), 512'd0);
    tx_full = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_txv", 512'(tx_valid), 512'd0);
    req_data[255:0] = pay[2];
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    tick();
    chk("post_txv1", 512'(tx_valid), 512'd1);
    chk("post_msg", tx_data, msg(64'd1, 64'd0, 64'd0, pay[2]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
